// File: rtl/seq_alu.sv
// seq_alu: handshaked WIDTH-bit ALU with registered Result and NZCV flags.
// There are eight operations. All of them finish in one cycle except MUL,
// which can be built as an iterative shift-add multiplier.
// Optional feature macro: SEQ_ALU_MUL_EN
//   defined   : opcode 110 runs the multiplier for WIDTH cycles (busy is high meanwhile)
//   undefined : no multiplier; opcode 110 completes in 1 cycle with
//               Result=0 and ALUFlags=4'b0101, which marks it unsupported
module seq_alu #(
    parameter int WIDTH = 32,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       ALUControl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic [3:0]       ALUFlags,
    output logic             busy
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_SRA = 3'b111;

`ifdef SEQ_ALU_MUL_EN
    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, HOLD = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd2} state_t;
`endif

    state_t state, next_state;

    logic             load_res;
    logic [WIDTH-1:0] res_nxt;
    logic [3:0]       flags_nxt;
    logic [WIDTH-1:0] alu_res;
    logic [3:0]       alu_flags;

    // Pack {N,Z,C,V} from a result and its carry/overflow terms.
    function automatic logic [3:0] pack_flags(input logic [WIDTH-1:0] r,
                                              input logic c, input logic v);
        return {r[WIDTH-1], (r == '0), c, v};
    endfunction

    // Single-cycle operations. Returns {flags, result}. Opcode 110 gives the
    // "unsupported" encoding (Result=0, Z=1, V=1). It is used only when the
    // multiplier is not built.
    function automatic logic [WIDTH+3:0] alu_eval(input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] y,
                                                  input logic [2:0]       op);
        logic [WIDTH:0]   sum;
        logic [WIDTH-1:0] res;
        logic [SHW-1:0]   sh;
        logic             sub;
        logic             c;
        logic             v;
        sub = (op == OP_SUB);
        sh  = y[SHW-1:0];
        sum = {1'b0, x} + {1'b0, (sub ? ~y : y)} + {{WIDTH{1'b0}}, sub};
        res = '0;
        c   = 1'b0;
        v   = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                res = sum[WIDTH-1:0];
                c   = sum[WIDTH];
                v   = ~(x[WIDTH-1] ^ y[WIDTH-1] ^ sub) & (x[WIDTH-1] ^ sum[WIDTH-1]);
            end
            OP_AND: res = x & y;
            OP_OR:  res = x | y;
            OP_XOR: res = x ^ y;
            OP_SLL: res = x << sh;
            OP_SRA: res = $signed(x) >>> sh;
            OP_MUL: v = 1'b1;
            default: res = '0;
        endcase
        return {pack_flags(res, c, v), res};
    endfunction

    assign {alu_flags, alu_res} = alu_eval(a, b, ALUControl);

`ifdef SEQ_ALU_MUL_EN
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0]   mplier;
    logic [SHW-1:0]     cnt;
    logic               mul_start;
    logic               mul_last;

    assign acc_nxt  = mplier[0] ? (acc + mcand) : acc;
    assign mul_last = (cnt == SHW'(WIDTH - 1));
    assign busy     = (state == MUL);

    // Shift-add multiplier, LSB of the multiplier first. There is no early-out.
    always_ff @(posedge clk) begin
        if (mul_start) begin
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
        end else if (state == MUL) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
        end
    end
`else
    assign busy = 1'b0;
`endif

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == HOLD);

    // State register. Reset discards any operation in flight.
    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    // Next-state logic and the result-load selection.
    always_comb begin
        next_state = state;
        load_res   = 1'b0;
        res_nxt    = alu_res;
        flags_nxt  = alu_flags;
`ifdef SEQ_ALU_MUL_EN
        mul_start  = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (in_valid) begin
`ifdef SEQ_ALU_MUL_EN
                    if (ALUControl == OP_MUL) begin
                        mul_start  = 1'b1;
                        next_state = MUL;
                    end else begin
                        load_res   = 1'b1;
                        next_state = HOLD;
                    end
`else
                    load_res   = 1'b1;
                    next_state = HOLD;
`endif
                end
            end
`ifdef SEQ_ALU_MUL_EN
            MUL: begin
                if (mul_last) begin
                    load_res   = 1'b1;
                    res_nxt    = acc_nxt[WIDTH-1:0];
                    flags_nxt  = pack_flags(acc_nxt[WIDTH-1:0], 1'b0,
                                            |acc_nxt[2*WIDTH-1:WIDTH]);
                    next_state = HOLD;
                end
            end
`endif
            HOLD: begin
                if (out_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Result/flag registers. They hold their value until the next completion.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            Result   <= '0;
            ALUFlags <= '0;
        end else if (load_res) begin
            Result   <= res_nxt;
            ALUFlags <= flags_nxt;
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Testbench for seq_alu (WIDTH=32). It applies table-driven vectors and
// hand-written sequences for backpressure and reset. Expectations follow
// SEQ_ALU_MUL_EN.
module tb_seq_alu;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  ALUControl;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Result;
    logic [3:0]  ALUFlags;
    logic        busy;

    int checks = 0;
    int errors = 0;

    seq_alu #(.WIDTH(32)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .ALUControl(ALUControl), .out_valid(out_valid),
        .out_ready(out_ready), .Result(Result), .ALUFlags(ALUFlags), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [31:0] res;
        logic [3:0]  flags;
        int          lat;
        int          bsy;
    } vec_t;

    localparam int NV = 18;
    vec_t vt[NV];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called #1 after an edge while the DUT is idle. It returns the latency
    // in cycles and the number of samples in which busy was high.
    task automatic do_op(input logic [31:0] ia, input logic [31:0] ib, input logic [2:0] iop,
                         output int lat, output int bcnt);
        check("in_ready before accept", {63'd0, in_ready}, 64'd1);
        a = ia; b = ib; ALUControl = iop; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom; ALUControl = 3'($urandom_range(0, 7));
        lat  = 1;
        bcnt = busy ? 1 : 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
            if (busy) bcnt++;
        end
    endtask

    task automatic consume(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, " out_valid after consume"}, {63'd0, out_valid}, 64'd0);
        check({tag, " in_ready after consume"}, {63'd0, in_ready}, 64'd1);
    endtask

    initial begin
        int lat;
        int bc;
        int stray;

        //            a             b             op      res           flags    lat bsy
        vt[0]  = '{32'h7FFFFFFF, 32'h00000001, 3'b000, 32'h80000000, 4'b1001, 1, 0};
        vt[1]  = '{32'hFFFFFFFF, 32'h00000001, 3'b000, 32'h00000000, 4'b0110, 1, 0};
        vt[2]  = '{32'h80000000, 32'h80000000, 3'b000, 32'h00000000, 4'b0111, 1, 0};
        vt[3]  = '{32'h00000005, 32'h00000005, 3'b001, 32'h00000000, 4'b0110, 1, 0};
        vt[4]  = '{32'h00000003, 32'h00000005, 3'b001, 32'hFFFFFFFE, 4'b1000, 1, 0};
        vt[5]  = '{32'h80000000, 32'h00000001, 3'b001, 32'h7FFFFFFF, 4'b0011, 1, 0};
        vt[6]  = '{32'hF0F0F0F0, 32'h0FF00FF0, 3'b010, 32'h00F000F0, 4'b0000, 1, 0};
        vt[7]  = '{32'h00000000, 32'h00000000, 3'b011, 32'h00000000, 4'b0100, 1, 0};
        vt[8]  = '{32'hA5A5A5A5, 32'hFFFFFFFF, 3'b100, 32'h5A5A5A5A, 4'b0000, 1, 0};
        vt[9]  = '{32'h80000000, 32'h00000004, 3'b111, 32'hF8000000, 4'b1000, 1, 0};
        vt[10] = '{32'h00000001, 32'h00000021, 3'b101, 32'h00000002, 4'b0000, 1, 0};
        vt[11] = '{32'h12345678, 32'h00000000, 3'b101, 32'h12345678, 4'b0000, 1, 0};
        vt[12] = '{32'h40000000, 32'h0000001F, 3'b111, 32'h00000000, 4'b0100, 1, 0};
        vt[13] = '{32'h00000001, 32'h0000001F, 3'b101, 32'h80000000, 4'b1000, 1, 0};
`ifdef SEQ_ALU_MUL_EN
        vt[14] = '{32'd1234,     32'd5678,     3'b110, 32'd7006652,  4'b0000, 33, 32};
        vt[15] = '{32'h00010000, 32'h00010000, 3'b110, 32'h00000000, 4'b0101, 33, 32};
        vt[16] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 3'b110, 32'h00000001, 4'b0001, 33, 32};
        vt[17] = '{32'h00000005, 32'h00000000, 3'b110, 32'h00000000, 4'b0100, 33, 32};
`else
        vt[14] = '{32'd1234,     32'd5678,     3'b110, 32'h00000000, 4'b0101, 1, 0};
        vt[15] = '{32'h00010000, 32'h00010000, 3'b110, 32'h00000000, 4'b0101, 1, 0};
        vt[16] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 3'b110, 32'h00000000, 4'b0101, 1, 0};
        vt[17] = '{32'h00000005, 32'h00000000, 3'b110, 32'h00000000, 4'b0101, 1, 0};
`endif

        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; ALUControl = '0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        check("reset Result", {32'd0, Result}, 64'd0);
        check("reset ALUFlags", {60'd0, ALUFlags}, 64'd0);
        check("reset out_valid", {63'd0, out_valid}, 64'd0);
        check("reset in_ready", {63'd0, in_ready}, 64'd1);
        check("reset busy", {63'd0, busy}, 64'd0);

        for (int i = 0; i < NV; i++) begin
            do_op(vt[i].a, vt[i].b, vt[i].op, lat, bc);
            check($sformatf("v%0d latency", i), 64'(lat), 64'(vt[i].lat));
            check($sformatf("v%0d busy cycles", i), 64'(bc), 64'(vt[i].bsy));
            check($sformatf("v%0d Result", i), {32'd0, Result}, {32'd0, vt[i].res});
            check($sformatf("v%0d ALUFlags", i), {60'd0, ALUFlags}, {60'd0, vt[i].flags});
            check($sformatf("v%0d in_ready in HOLD", i), {63'd0, in_ready}, 64'd0);
            consume($sformatf("v%0d", i));
        end

        // Backpressure: the result must stay stable while a second op is held off.
        do_op(32'd5, 32'd5, 3'b001, lat, bc);
        check("bp first Result", {32'd0, Result}, 64'd0);
        a = 32'd2; b = 32'd3; ALUControl = 3'b000; in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check($sformatf("bp%0d out_valid", k), {63'd0, out_valid}, 64'd1);
            check($sformatf("bp%0d in_ready", k), {63'd0, in_ready}, 64'd0);
            check($sformatf("bp%0d Result", k), {32'd0, Result}, 64'd0);
            check($sformatf("bp%0d ALUFlags", k), {60'd0, ALUFlags}, 64'b0110);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp consumed out_valid", {63'd0, out_valid}, 64'd0);
        check("bp consumed in_ready", {63'd0, in_ready}, 64'd1);
        check("bp Result kept in IDLE", {32'd0, Result}, 64'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp second out_valid", {63'd0, out_valid}, 64'd1);
        check("bp second Result", {32'd0, Result}, 64'd5);
        check("bp second ALUFlags", {60'd0, ALUFlags}, 64'd0);
        consume("bp second");

        // Reset and out_ready arrive together in HOLD: reset wins.
        do_op(32'd1, 32'd1, 3'b000, lat, bc);
        check("hold-rst pre Result", {32'd0, Result}, 64'd2);
        out_ready = 1'b1; reset_n = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b0; reset_n = 1'b1;
        check("hold-rst out_valid", {63'd0, out_valid}, 64'd0);
        check("hold-rst Result", {32'd0, Result}, 64'd0);
        check("hold-rst ALUFlags", {60'd0, ALUFlags}, 64'd0);
        check("hold-rst in_ready", {63'd0, in_ready}, 64'd1);

`ifdef SEQ_ALU_MUL_EN
        // Reset in the middle of a multiply discards the multiply.
        do_op(32'd1, 32'd2, 3'b000, lat, bc);
        consume("pre-mul-rst");
        a = 32'd7; b = 32'd9; ALUControl = 3'b110; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("mul-rst busy before reset", {63'd0, busy}, 64'd1);
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        check("mul-rst Result", {32'd0, Result}, 64'd0);
        check("mul-rst ALUFlags", {60'd0, ALUFlags}, 64'd0);
        check("mul-rst out_valid", {63'd0, out_valid}, 64'd0);
        check("mul-rst in_ready", {63'd0, in_ready}, 64'd1);
        check("mul-rst busy", {63'd0, busy}, 64'd0);
        stray = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (out_valid || busy) stray++;
        end
        check("mul-rst stray completion", 64'(stray), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
